apb4_mem_slave: RTL and testbench
=================================

Name: apb4_mem_slave

Overview:
- Parametrised APB4 memory slave: next generation of the team's APB slave, with configurable data width, depth, base address and wait states.
- Adds address-window decode, byte-strobe writes, PSLVERR reporting and a registered wait-state FSM.
- Sits behind the APB bridge as a scratch-RAM or register-bank endpoint.

Parameters:
ADDR_WIDTH, 32, paddr width
DATA_WIDTH, 32, pwdata/prdata width; multiple of 8, range 8..64
DATA_STRB, DATA_WIDTH/8, pstrb width (derived, not overridden)
MEM_DEPTH, 16, number of DATA_WIDTH words; power of 2, >=2
BASE_ADDR, 32'hA200_0000, byte address of word 0; aligned to MEM_DEPTH*DATA_STRB
WAIT_STATES, 0, extra access-phase cycles before pready; 0..15

Ports:
clk  input  1  clock; all logic on posedge
rst  input  1  asynchronous, active-high reset
paddr  input  ADDR_WIDTH  byte address
prot  input  3  APB4 PPROT
pwrite  input  1  1=write, 0=read
psel  input  1  slave select
penable  input  1  access phase
pwdata  input  DATA_WIDTH  write data
pstrb  input  DATA_STRB  write byte lanes
pready  output  1  transfer complete
slverr  output  1  error response; qualified by pready
prdata  output  DATA_WIDTH  read data; valid when pready & !pwrite

Behaviour:
- Reset (rst=1, async): pready=0, slverr=0, prdata=0, FSM=IDLE, wait counter=0, all memory words=0.
- Decode, evaluated on the setup-phase cycle: off = paddr - BASE_ADDR, truncated to ADDR_WIDTH bits.
  - Hit when off < MEM_DEPTH*DATA_STRB and off[log2(DATA_STRB)-1:0]==0.
  - Word index = off >> log2(DATA_STRB).
  - Miss or misaligned sets err=1.
- FSM states: IDLE, WAIT, RESP.
- IDLE:
  - Setup edge: psel=1 & penable=0 sampled. Latch pwrite, index and err. Load counter=WAIT_STATES.
  - Next state is WAIT if WAIT_STATES>0, otherwise RESP.
  - psel=0, or penable=1 without a preceding setup phase: stay in IDLE; no response.
- WAIT:
  - Counter decrements each cycle; moves to RESP on the edge where it reaches 0.
  - psel=0 (aborted transfer): return to IDLE; no write; no response.
- RESP:
  - pready=1. slverr=err_latched.
  - On the edge with psel & penable: write commits if pwrite & !err. FSM returns to IDLE.
  - psel dropped: return to IDLE; no write.
- pready and slverr are registered and driven from FSM state only. slverr is 0 whenever pready=0.
- Latency: pready asserts in access-phase cycle WAIT_STATES+1.
- Back-to-back transfers: a new setup phase in the cycle after RESP is accepted with no idle cycle.
- Read path:
  - prdata is loaded at the setup edge from mem[index], or 0 on err.
  - It holds until the next read setup edge; writes do not change prdata.
- Write path:
  - Only byte lanes with pstrb[i]=1 are updated.
  - pstrb=0 gives no memory change and no error.
  - pwdata and pstrb are sampled at the RESP commit edge.
- Read-after-write to the same word returns the new data: the read setup edge follows the write commit edge.
- Reset mid-transfer aborts it immediately; memory is cleared; no partial write.
- pstrb is ignored on reads.

Optional Feature:
- Macro: APB4_MEM_SLAVE_PROT_CHECK_EN.
- Defined:
  - Setup phase with prot[1]=1 (non-secure) sets err=1, exactly like an address miss.
  - Result: slverr=1 with pready, no write, prdata=0.
  - prot[0] and prot[2] are ignored.
- Undefined: prot is ignored entirely; the decode logic does not reference it.

Test Plan:
- Zero-wait write then read, defaults: write 32'hDEAD_BEEF, pstrb=4'hF, to 32'hA200_0008; then read the same address -> pready in the first access cycle both times, prdata=32'hDEAD_BEEF, slverr=0.
- Byte strobe: word 3 preloaded 32'h1122_3344; write 32'hAABB_CCDD with pstrb=4'b0101 -> read returns 32'h11BB_33DD.
- Wait states, WAIT_STATES=2: read at 32'hA200_0004 -> pready low for 2 access cycles, high in the 3rd; penable held high throughout.
- Errors:
  - Write to 32'hA200_0040 (out of range) and to 32'hA200_0002 (misaligned) -> slverr=1 with pready, memory unchanged.
  - Read at 32'hA200_0040 -> prdata=0.
- Abort and reset: psel dropped in WAIT -> IDLE, no write. rst pulsed mid-WAIT -> pready=0 and prdata=0 immediately, all words read 0 afterwards.
- Macro defined: write with prot=3'b010 -> slverr=1, word unchanged. Same write with prot=3'b000 -> succeeds. Macro undefined: both writes succeed.

Source files
------------

// File: rtl/apb4_mem_slave_if.sv
// APB4 bus bundle for apb4_mem_slave: requester-driven request signals and
// slave-driven response signals, with master/slave modports.
interface apb4_mem_slave_if #(
    parameter int ADDR_WIDTH = 32,
    parameter int DATA_WIDTH = 32
);
    localparam int DATA_STRB = DATA_WIDTH / 8;

    logic [ADDR_WIDTH-1:0] paddr;
    logic [2:0]            prot;
    logic                  pwrite;
    logic                  psel;
    logic                  penable;
    logic [DATA_WIDTH-1:0] pwdata;
    logic [DATA_STRB-1:0]  pstrb;
    logic                  pready;
    logic                  slverr;
    logic [DATA_WIDTH-1:0] prdata;

    modport master (
        output paddr, prot, pwrite, psel, penable, pwdata, pstrb,
        input  pready, slverr, prdata
    );

    modport slave (
        input  paddr, prot, pwrite, psel, penable, pwdata, pstrb,
        output pready, slverr, prdata
    );
endinterface

// File: rtl/apb4_mem_slave.sv
// Parametrised APB4 memory slave with window decode, byte strobes, PSLVERR and a
// registered wait-state FSM. Define APB4_MEM_SLAVE_PROT_CHECK_EN to reject non-secure accesses.
module apb4_mem_slave #(
    parameter int                    ADDR_WIDTH  = 32,
    parameter int                    DATA_WIDTH  = 32,
    parameter int                    MEM_DEPTH   = 16,
    parameter logic [ADDR_WIDTH-1:0] BASE_ADDR   = ADDR_WIDTH'(32'hA200_0000),
    parameter int                    WAIT_STATES = 0
) (
    input logic             clk,
    input logic             rst,
    apb4_mem_slave_if.slave bus
);
    localparam int DATA_STRB = DATA_WIDTH / 8;
    localparam int OFF_LSB   = $clog2(DATA_STRB);
    localparam int IDX_W     = $clog2(MEM_DEPTH);
    localparam logic [ADDR_WIDTH-1:0] WIN_BYTES  = ADDR_WIDTH'(MEM_DEPTH * DATA_STRB);
    localparam logic [ADDR_WIDTH-1:0] ALIGN_MASK = ADDR_WIDTH'(DATA_STRB - 1);
    localparam logic [3:0]            WAIT_LOAD  = 4'(WAIT_STATES);

    // Elaboration-time guards on the legal parameter space.
    if ((DATA_WIDTH % 8) != 0 || DATA_WIDTH < 8 || DATA_WIDTH > 64) begin : g_bad_width
        $error("apb4_mem_slave: DATA_WIDTH must be a multiple of 8 in 8..64");
    end
    if (MEM_DEPTH < 2 || (MEM_DEPTH & (MEM_DEPTH - 1)) != 0) begin : g_bad_depth
        $error("apb4_mem_slave: MEM_DEPTH must be a power of 2, >= 2");
    end
    if (WAIT_STATES < 0 || WAIT_STATES > 15) begin : g_bad_wait
        $error("apb4_mem_slave: WAIT_STATES must be in 0..15");
    end
    if ((BASE_ADDR & (WIN_BYTES - 1'b1)) != '0) begin : g_bad_base
        $error("apb4_mem_slave: BASE_ADDR must be aligned to the window size");
    end

    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_WAIT = 2'd1,
        ST_RESP = 2'd2
    } state_e;

    typedef logic [DATA_WIDTH-1:0] word_t;

    state_e             state_q,  state_d;
    logic [3:0]         cnt_q,    cnt_d;
    logic               write_q,  write_d;
    logic [IDX_W-1:0]   idx_q,    idx_d;
    logic               err_q,    err_d;
    logic               pready_q, pready_d;
    logic               slverr_q, slverr_d;
    word_t              prdata_q, prdata_d;
    word_t              mem_q [MEM_DEPTH];
    word_t              mem_d [MEM_DEPTH];

    logic [ADDR_WIDTH-1:0] off;
    logic                  dec_err;
    logic [IDX_W-1:0]      dec_idx;

    // Window decode; the offset wraps, so addresses below BASE_ADDR land far out of range.
    always_comb begin
        off     = bus.paddr - BASE_ADDR;
        dec_err = !((off < WIN_BYTES) && ((off & ALIGN_MASK) == '0));
`ifdef APB4_MEM_SLAVE_PROT_CHECK_EN
        if (bus.prot[1]) begin
            dec_err = 1'b1;
        end
`endif
        dec_idx = off[OFF_LSB +: IDX_W];
    end

    // NOTE: every signal gets a default at the top of the block so no path leaves
    // a value unassigned; otherwise synthesis infers a latch.
    always_comb begin
        state_d  = state_q;
        cnt_d    = cnt_q;
        write_d  = write_q;
        idx_d    = idx_q;
        err_d    = err_q;
        prdata_d = prdata_q;
        mem_d    = mem_q;
        pready_d = 1'b0;
        slverr_d = 1'b0;

        unique case (state_q)
            ST_IDLE: begin
                if (bus.psel && !bus.penable) begin
                    write_d = bus.pwrite;
                    idx_d   = dec_idx;
                    err_d   = dec_err;
                    cnt_d   = WAIT_LOAD;
                    if (!bus.pwrite) begin
                        prdata_d = dec_err ? '0 : mem_q[dec_idx];
                    end
                    if (WAIT_STATES > 0) begin
                        state_d = ST_WAIT;
                    end else begin
                        state_d  = ST_RESP;
                        pready_d = 1'b1;
                        slverr_d = dec_err;
                    end
                end
            end

            ST_WAIT: begin
                if (!bus.psel) begin
                    state_d = ST_IDLE;
                end else begin
                    cnt_d = cnt_q - 4'd1;
                    if (cnt_q == 4'd1) begin
                        state_d  = ST_RESP;
                        pready_d = 1'b1;
                        slverr_d = err_q;
                    end
                end
            end

            ST_RESP: begin
                state_d = ST_IDLE;
                // Data and strobes are taken from the bus on the completing edge itself.
                if (bus.psel && bus.penable && write_q && !err_q) begin
                    for (int b = 0; b < DATA_STRB; b++) begin
                        if (bus.pstrb[b]) begin
                            mem_d[idx_q][8*b +: 8] = bus.pwdata[8*b +: 8];
                        end
                    end
                end
            end

            default: begin
                state_d = ST_IDLE;
            end
        endcase
    end

    // NOTE: sequential state uses non-blocking assignments so every flop samples
    // the pre-edge value of its inputs, independent of statement order.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q  <= ST_IDLE;
            cnt_q    <= '0;
            write_q  <= 1'b0;
            idx_q    <= '0;
            err_q    <= 1'b0;
            pready_q <= 1'b0;
            slverr_q <= 1'b0;
            prdata_q <= '0;
            // NOTE: the storage array is cleared by reset because the block must
            // come up reading zeros; this forces flop storage rather than a RAM macro.
            for (int w = 0; w < MEM_DEPTH; w++) begin
                mem_q[w] <= '0;
            end
        end else begin
            state_q  <= state_d;
            cnt_q    <= cnt_d;
            write_q  <= write_d;
            idx_q    <= idx_d;
            err_q    <= err_d;
            pready_q <= pready_d;
            slverr_q <= slverr_d;
            prdata_q <= prdata_d;
            mem_q    <= mem_d;
        end
    end

    assign bus.pready = pready_q;
    assign bus.slverr = slverr_q;
    assign bus.prdata = prdata_q;

endmodule

// File: tb/tb_apb4_mem_slave.sv
// Self-checking bench for apb4_mem_slave: a zero-wait instance driven from a vector
// table, and a two-wait-state instance for latency, abort and reset sequences.
module tb_apb4_mem_slave;

`ifdef APB4_MEM_SLAVE_PROT_CHECK_EN
    localparam bit PROT_EN = 1'b1;
`else
    localparam bit PROT_EN = 1'b0;
`endif

    logic        clk = 1'b0;
    logic        rst;
    logic        dsel;
    logic [31:0] paddr;
    logic [2:0]  prot;
    logic        pwrite;
    logic        psel;
    logic        penable;
    logic [31:0] pwdata;
    logic [3:0]  pstrb;

    int n_tests = 0;
    int n_fail  = 0;

    always #5 clk = ~clk;

    apb4_mem_slave_if #(.ADDR_WIDTH(32), .DATA_WIDTH(32)) bus0 ();
    apb4_mem_slave_if #(.ADDR_WIDTH(32), .DATA_WIDTH(32)) bus2 ();

    assign bus0.paddr   = paddr;
    assign bus0.prot    = prot;
    assign bus0.pwrite  = pwrite;
    assign bus0.psel    = psel & ~dsel;
    assign bus0.penable = penable;
    assign bus0.pwdata  = pwdata;
    assign bus0.pstrb   = pstrb;

    assign bus2.paddr   = paddr;
    assign bus2.prot    = prot;
    assign bus2.pwrite  = pwrite;
    assign bus2.psel    = psel & dsel;
    assign bus2.penable = penable;
    assign bus2.pwdata  = pwdata;
    assign bus2.pstrb   = pstrb;

    apb4_mem_slave #(.WAIT_STATES(0)) u_dut0 (.clk(clk), .rst(rst), .bus(bus0));
    apb4_mem_slave #(.WAIT_STATES(2)) u_dut2 (.clk(clk), .rst(rst), .bus(bus2));

    logic        sel_rdy;
    logic        sel_err;
    logic [31:0] sel_rd;
    assign sel_rdy = dsel ? bus2.pready : bus0.pready;
    assign sel_err = dsel ? bus2.slverr : bus0.slverr;
    assign sel_rd  = dsel ? bus2.prdata : bus0.prdata;

    typedef struct {
        logic        wr;
        logic [31:0] addr;
        logic [31:0] wdata;
        logic [3:0]  strb;
        logic [2:0]  prot;
        logic        exp_err;
        logic        chk_rd;
        logic [31:0] exp_rd;
    } vec_t;

    localparam int NVEC = 19;
    vec_t vec [NVEC];

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_tests++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %h, expected %h", name, act, exp);
        end
    endtask

    // One APB transfer; returns the access cycle in which pready was seen (20 = timeout).
    task automatic apb_xfer(input logic d, input logic wr, input logic [31:0] a,
                            input logic [31:0] wd, input logic [3:0] st, input logic [2:0] pr,
                            output int cyc, output logic err, output logic [31:0] rd);
        @(negedge clk);
        dsel    = d;
        psel    = 1'b1;
        penable = 1'b0;
        pwrite  = wr;
        paddr   = a;
        pwdata  = wd;
        pstrb   = st;
        prot    = pr;
        @(negedge clk);
        penable = 1'b1;
        cyc     = 1;
        #1;
        while (!sel_rdy && cyc < 20) begin
            @(negedge clk);
            #1;
            cyc++;
        end
        err = sel_err;
        rd  = sel_rd;
    endtask

    task automatic bus_idle();
        @(negedge clk);
        psel    = 1'b0;
        penable = 1'b0;
    endtask

    int          cyc;
    logic        err;
    logic [31:0] rd;

    initial begin
        vec[0]  = '{1'b1, 32'hA200_0008, 32'hDEAD_BEEF, 4'hF,    3'b000, 1'b0,    1'b0, 32'h0};
        vec[1]  = '{1'b0, 32'hA200_0008, 32'h0,         4'hF,    3'b000, 1'b0,    1'b1, 32'hDEAD_BEEF};
        vec[2]  = '{1'b1, 32'hA200_000C, 32'h1122_3344, 4'hF,    3'b000, 1'b0,    1'b0, 32'h0};
        vec[3]  = '{1'b1, 32'hA200_000C, 32'hAABB_CCDD, 4'b0101, 3'b000, 1'b0,    1'b0, 32'h0};
        vec[4]  = '{1'b0, 32'hA200_000C, 32'h0,         4'h0,    3'b000, 1'b0,    1'b1, 32'h11BB_33DD};
        vec[5]  = '{1'b1, 32'hA200_0040, 32'h1234_5678, 4'hF,    3'b000, 1'b1,    1'b0, 32'h0};
        vec[6]  = '{1'b1, 32'hA200_0002, 32'h1234_5678, 4'hF,    3'b000, 1'b1,    1'b0, 32'h0};
        vec[7]  = '{1'b0, 32'hA200_0000, 32'h0,         4'h0,    3'b000, 1'b0,    1'b1, 32'h0};
        vec[8]  = '{1'b0, 32'hA200_0040, 32'h0,         4'h0,    3'b000, 1'b1,    1'b1, 32'h0};
        vec[9]  = '{1'b0, 32'hA200_0008, 32'h0,         4'h0,    3'b000, 1'b0,    1'b1, 32'hDEAD_BEEF};
        vec[10] = '{1'b1, 32'hA200_0008, 32'h0,         4'h0,    3'b000, 1'b0,    1'b0, 32'h0};
        vec[11] = '{1'b0, 32'hA200_0008, 32'h0,         4'h0,    3'b000, 1'b0,    1'b1, 32'hDEAD_BEEF};
        vec[12] = '{1'b1, 32'hA200_003C, 32'hCAFE_F00D, 4'hF,    3'b000, 1'b0,    1'b0, 32'h0};
        vec[13] = '{1'b0, 32'hA200_003C, 32'h0,         4'h0,    3'b000, 1'b0,    1'b1, 32'hCAFE_F00D};
        vec[14] = '{1'b0, 32'hA1FF_FFFC, 32'h0,         4'h0,    3'b000, 1'b1,    1'b1, 32'h0};
        vec[15] = '{1'b1, 32'hA200_0010, 32'h5555_5555, 4'hF,    3'b010, PROT_EN, 1'b0, 32'h0};
        vec[16] = '{1'b0, 32'hA200_0010, 32'h0,         4'h0,    3'b000, 1'b0,    1'b1,
                    PROT_EN ? 32'h0 : 32'h5555_5555};
        vec[17] = '{1'b1, 32'hA200_0010, 32'h6666_6666, 4'hF,    3'b000, 1'b0,    1'b0, 32'h0};
        vec[18] = '{1'b0, 32'hA200_0010, 32'h0,         4'h0,    3'b000, 1'b0,    1'b1, 32'h6666_6666};

        rst = 1'b1; dsel = 1'b0; psel = 1'b0; penable = 1'b0; pwrite = 1'b0;
        paddr = '0; pwdata = '0; pstrb = '0; prot = '0;
        repeat (2) @(negedge clk);
        check("reset pready0", 32'(bus0.pready), 32'd0);
        check("reset slverr0", 32'(bus0.slverr), 32'd0);
        check("reset prdata0", bus0.prdata, 32'd0);
        check("reset pready2", 32'(bus2.pready), 32'd0);
        check("reset prdata2", bus2.prdata, 32'd0);
        rst = 1'b0;
        @(negedge clk);

        // Zero-wait instance, back-to-back transfers from the table.
        for (int i = 0; i < NVEC; i++) begin
            apb_xfer(1'b0, vec[i].wr, vec[i].addr, vec[i].wdata, vec[i].strb, vec[i].prot,
                     cyc, err, rd);
            check($sformatf("vec%0d ready_cycle", i), 32'(cyc), 32'd1);
            check($sformatf("vec%0d slverr", i), 32'(err), 32'(vec[i].exp_err));
            if (vec[i].chk_rd) check($sformatf("vec%0d prdata", i), rd, vec[i].exp_rd);
        end
        bus_idle();
        repeat (2) @(negedge clk);
        check("idle pready0", 32'(bus0.pready), 32'd0);

        // Two wait states: pready in the third access cycle.
        apb_xfer(1'b1, 1'b1, 32'hA200_0004, 32'h0BAD_C0DE, 4'hF, 3'b000, cyc, err, rd);
        check("ws2 write ready_cycle", 32'(cyc), 32'd3);
        check("ws2 write slverr", 32'(err), 32'd0);
        apb_xfer(1'b1, 1'b0, 32'hA200_0004, 32'h0, 4'h0, 3'b000, cyc, err, rd);
        check("ws2 read ready_cycle", 32'(cyc), 32'd3);
        check("ws2 read prdata", rd, 32'h0BAD_C0DE);
        apb_xfer(1'b1, 1'b1, 32'hA200_0000, 32'h7777_7777, 4'hF, 3'b000, cyc, err, rd);
        check("ws2 prdata held over write", rd, 32'h0BAD_C0DE);
        apb_xfer(1'b1, 1'b1, 32'hA200_0044, 32'h7777_7777, 4'hF, 3'b000, cyc, err, rd);
        check("ws2 miss ready_cycle", 32'(cyc), 32'd3);
        check("ws2 miss slverr", 32'(err), 32'd1);

        // Abort in WAIT: psel dropped after the first access cycle.
        @(negedge clk);
        dsel = 1'b1; psel = 1'b1; penable = 1'b0; pwrite = 1'b1;
        paddr = 32'hA200_0004; pwdata = 32'h1111_1111; pstrb = 4'hF; prot = 3'b000;
        @(negedge clk);
        penable = 1'b1;
        #1 check("abort pready in wait", 32'(bus2.pready), 32'd0);
        @(negedge clk);
        psel = 1'b0; penable = 1'b0;
        repeat (4) @(negedge clk);
        check("abort no response", 32'(bus2.pready), 32'd0);
        apb_xfer(1'b1, 1'b0, 32'hA200_0004, 32'h0, 4'h0, 3'b000, cyc, err, rd);
        check("abort no write", rd, 32'h0BAD_C0DE);

        // Reset pulsed mid-WAIT.
        @(negedge clk);
        dsel = 1'b1; psel = 1'b1; penable = 1'b0; pwrite = 1'b0;
        paddr = 32'hA200_0004; prot = 3'b000;
        @(negedge clk);
        penable = 1'b1;
        #1 check("setup loads prdata", bus2.prdata, 32'h0BAD_C0DE);
        rst = 1'b1;
        #1;
        check("rst prdata2", bus2.prdata, 32'd0);
        check("rst pready2", 32'(bus2.pready), 32'd0);
        check("rst prdata0", bus0.prdata, 32'd0);
        @(negedge clk);
        rst = 1'b0; psel = 1'b0; penable = 1'b0;
        for (int w = 0; w < 16; w++) begin
            apb_xfer(1'b1, 1'b0, 32'hA200_0000 + 32'(4 * w), 32'h0, 4'h0, 3'b000, cyc, err, rd);
            check($sformatf("post-rst word%0d", w), rd, 32'd0);
        end
        apb_xfer(1'b0, 1'b0, 32'hA200_003C, 32'h0, 4'h0, 3'b000, cyc, err, rd);
        check("post-rst dut0 word15", rd, 32'd0);
        apb_xfer(1'b0, 1'b0, 32'hA200_0010, 32'h0, 4'h0, 3'b000, cyc, err, rd);
        check("post-rst dut0 word4", rd, 32'd0);
        bus_idle();

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL watchdog: simulation did not complete");
        $fatal(1);
    end

endmodule
